// File: rtl/swo_tx.sv
// swo_tx: byte FIFO feeding a single-wire SWO serialiser. NRZ UART framing by default;
// defining SWO_TX_MANCHESTER_EN selects ARM-style Manchester framing with a trailing low idle bit.
module swo_tx #(
  parameter int pFIFO_DEPTH  = 16,
  parameter int pDIV_WIDTH   = 12,
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                         fe_clk,
  input  logic                         reset,
  input  logic                         I_enable,
  input  logic [pDIV_WIDTH-1:0]        I_div,
  input  logic [7:0]                   I_data,
  input  logic                         I_valid,
  output logic                         O_ready,
  output logic                         O_swo,
  output logic                         O_busy,
  output logic [$clog2(pFIFO_DEPTH):0] O_fifo_count,
  output logic [pCOUNT_WIDTH-1:0]      O_bytes_sent
);
  localparam int AW = $clog2(pFIFO_DEPTH);
`ifdef SWO_TX_MANCHESTER_EN
  localparam logic IDLE_LVL = 1'b0;
`else
  localparam logic IDLE_LVL = 1'b1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t r_state, w_state_nxt;

  logic [7:0]              r_mem [pFIFO_DEPTH];
  logic [AW-1:0]           r_wptr, r_rptr;
  logic [AW:0]             r_count;
  logic                    w_push, w_pop, w_empty;
  logic [7:0]              w_rd_data;
  logic [pDIV_WIDTH-1:0]   r_div, r_cnt;
  logic [2:0]              r_idx;
  logic [7:0]              r_shift, w_shift_nxt;
  logic [pCOUNT_WIDTH-1:0] r_sent;
  logic                    r_swo, w_swo_nxt, w_cnt_end, w_bit_end;
`ifdef SWO_TX_MANCHESTER_EN
  logic                    r_half, w_half_nxt;
`endif

  // Depth is a power of two, so the count MSB alone flags full.
  assign w_empty      = (r_count == '0);
  assign O_ready      = ~r_count[AW];
  assign w_push       = I_valid & O_ready;
  assign w_rd_data    = r_mem[r_rptr];
  assign O_fifo_count = r_count;
  assign O_busy       = (r_state != S_IDLE);
  assign O_swo        = r_swo;
  assign O_bytes_sent = r_sent;

  always_ff @(posedge fe_clk) begin
    if (w_push) r_mem[r_wptr] <= I_data;
  end

  always_ff @(posedge fe_clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign w_cnt_end = (r_cnt == r_div);
`ifdef SWO_TX_MANCHESTER_EN
  assign w_bit_end = w_cnt_end & r_half;
`else
  assign w_bit_end = w_cnt_end;
`endif

  // FSM: state register
  always_ff @(posedge fe_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state; STOP (gap bit in Manchester) chains straight into the next START
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE:  if (I_enable && !w_empty) begin
                 w_pop       = 1'b1;
                 w_state_nxt = S_START;
               end
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && r_idx == 3'd7) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_end) begin
                 if (I_enable && !w_empty) begin
                   w_pop       = 1'b1;
                   w_state_nxt = S_START;
                 end else begin
                   w_state_nxt = S_IDLE;
                 end
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs; line level is computed for the upcoming cycle so O_swo is registered
  always_comb begin
    w_swo_nxt   = IDLE_LVL;
    w_shift_nxt = r_shift;
    if (w_pop)                                 w_shift_nxt = w_rd_data;
    else if (r_state == S_DATA && w_bit_end)   w_shift_nxt = {1'b0, r_shift[7:1]};
`ifdef SWO_TX_MANCHESTER_EN
    w_half_nxt = r_half;
    if (w_pop)                                 w_half_nxt = 1'b0;
    else if (r_state != S_IDLE && w_cnt_end)   w_half_nxt = ~r_half;
    case (w_state_nxt)
      S_START: w_swo_nxt = ~w_half_nxt;
      S_DATA:  w_swo_nxt = w_shift_nxt[0] ^ w_half_nxt;
      default: w_swo_nxt = 1'b0;
    endcase
`else
    case (w_state_nxt)
      S_START: w_swo_nxt = 1'b0;
      S_DATA:  w_swo_nxt = w_shift_nxt[0];
      default: w_swo_nxt = 1'b1;
    endcase
`endif
  end

  always_ff @(posedge fe_clk or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_sent  <= '0;
      r_swo   <= IDLE_LVL;
`ifdef SWO_TX_MANCHESTER_EN
      r_half  <= 1'b0;
`endif
    end else begin
      r_swo   <= w_swo_nxt;
      r_shift <= w_shift_nxt;
`ifdef SWO_TX_MANCHESTER_EN
      r_half  <= w_half_nxt;
`endif
      if (w_pop) begin
        r_div <= I_div;
        r_cnt <= '0;
        r_idx <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
        if (r_state == S_DATA && w_bit_end) r_idx <= r_idx + 1'b1;
      end
      if (r_state == S_STOP && w_bit_end) r_sent <= r_sent + 1'b1;
    end
  end
endmodule

// File: tb/tb_swo_tx.sv
// Directed bench for swo_tx; the Manchester scenario runs when SWO_TX_MANCHESTER_EN is defined.
module tb_swo_tx;
  logic        fe_clk, reset, I_enable, I_valid;
  logic [11:0] I_div;
  logic [7:0]  I_data;
  logic        O_ready, O_swo, O_busy;
  logic [4:0]  O_fifo_count;
  logic [15:0] O_bytes_sent;
  int checks = 0;
  int errors = 0;
`ifdef SWO_TX_MANCHESTER_EN
  localparam logic IDLE = 1'b0;
`else
  localparam logic IDLE = 1'b1;
`endif

  swo_tx dut (
    .fe_clk(fe_clk), .reset(reset), .I_enable(I_enable), .I_div(I_div),
    .I_data(I_data), .I_valid(I_valid), .O_ready(O_ready), .O_swo(O_swo),
    .O_busy(O_busy), .O_fifo_count(O_fifo_count), .O_bytes_sent(O_bytes_sent)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  // Expected NRZ level k cycles into a frame: start 0, data LSB first, stop 1.
  function automatic logic nrz_bit(input logic [7:0] b, input int div, input int k);
    int bi;
    bi = k / (div + 1);
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge fe_clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; I_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; I_enable = 1'b0; I_valid = 1'b0; I_data = 8'h00; I_div = 12'd0;
    #3;
    checks++; if (O_swo !== IDLE) begin errors++; $display("FAIL reset_swo got %b exp %b", O_swo, IDLE); end
    checks++; if (O_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", O_ready); end
    checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", O_busy); end
    checks++; if (O_fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", O_fifo_count); end
    checks++; if (O_bytes_sent !== 16'd0) begin errors++; $display("FAIL reset_sent got %0d exp 0", O_bytes_sent); end
    do_reset();
    checks++; if (O_swo !== IDLE) begin errors++; $display("FAIL post_reset_swo got %b exp %b", O_swo, IDLE); end
  endtask

`ifndef SWO_TX_MANCHESTER_EN
  task automatic test_single();
    logic [39:0] exp;
    exp = 40'b0000_1111_0000_1111_0000_0000_1111_0000_1111_1111;
    do_reset();
    I_div = 12'd3; I_enable = 1'b1; I_data = 8'hA5; I_valid = 1'b1;
    step();
    I_valid = 1'b0;
    checks++; if (O_swo !== 1'b1) begin errors++; $display("FAIL single_pre got %b exp 1", O_swo); end
    for (int k = 0; k < 40; k++) begin
      step();
      checks++; if (O_swo !== exp[39-k]) begin errors++; $display("FAIL single_swo k=%0d got %b exp %b", k, O_swo, exp[39-k]); end
      if (k == 0) begin
        checks++; if (O_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", O_busy); end
      end
    end
    step();
    checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", O_busy); end
    checks++; if (O_bytes_sent !== 16'd1) begin errors++; $display("FAIL single_sent got %0d exp 1", O_bytes_sent); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic e;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
    do_reset();
    I_div = 12'd0; I_enable = 1'b1; I_data = bytes[0]; I_valid = 1'b1;
    step();
    for (int k = 0; k < 30; k++) begin
      if (k < 2) I_data = bytes[k+1];
      else I_valid = 1'b0;
      step();
      e = nrz_bit(bytes[k/10], 0, k % 10);
      checks++; if (O_swo !== e) begin errors++; $display("FAIL b2b_swo k=%0d got %b exp %b", k, O_swo, e); end
      checks++; if (O_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d got %b exp 1", k, O_busy); end
    end
    step();
    checks++; if (O_bytes_sent !== 16'd3) begin errors++; $display("FAIL b2b_sent got %0d exp 3", O_bytes_sent); end
    checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", O_busy); end
  endtask

  task automatic test_fifo_full();
    logic e;
    do_reset();
    I_div = 12'd3; I_enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      I_data = 8'h10 + 8'(i); I_valid = 1'b1;
      e = (i < 16);
      checks++; if (O_ready !== e) begin errors++; $display("FAIL full_ready i=%0d got %b exp %b", i, O_ready, e); end
      step();
    end
    I_valid = 1'b0;
    checks++; if (O_fifo_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", O_fifo_count); end
    checks++; if (O_swo !== 1'b1) begin errors++; $display("FAIL full_swo got %b exp 1", O_swo); end
    checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL full_busy got %b exp 0", O_busy); end
    I_enable = 1'b1;
    step();
    checks++; if (O_swo !== 1'b0) begin errors++; $display("FAIL full_start got %b exp 0", O_swo); end
    checks++; if (O_fifo_count !== 5'd15) begin errors++; $display("FAIL full_pop got %0d exp 15", O_fifo_count); end
    checks++; if (O_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %b exp 1", O_ready); end
    for (int k = 1; k < 40; k++) begin
      step();
      e = nrz_bit(8'h10, 3, k);
      checks++; if (O_swo !== e) begin errors++; $display("FAIL full_frame k=%0d got %b exp %b", k, O_swo, e); end
    end
  endtask

  task automatic test_div_change();
    logic e;
    do_reset();
    I_div = 12'd3; I_enable = 1'b1; I_data = 8'h3C; I_valid = 1'b1;
    step();
    for (int k = 0; k < 120; k++) begin
      if (k == 0) I_data = 8'hC3;
      if (k == 1) I_valid = 1'b0;
      if (k == 15) I_div = 12'd7;
      step();
      e = (k < 40) ? nrz_bit(8'h3C, 3, k) : nrz_bit(8'hC3, 7, k - 40);
      checks++; if (O_swo !== e) begin errors++; $display("FAIL div_swo k=%0d got %b exp %b", k, O_swo, e); end
    end
    step();
    checks++; if (O_bytes_sent !== 16'd2) begin errors++; $display("FAIL div_sent got %0d exp 2", O_bytes_sent); end
    checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL div_idle got %b exp 0", O_busy); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    I_div = 12'd3; I_enable = 1'b1; I_data = 8'h0F; I_valid = 1'b1;
    step();
    for (int k = 0; k < 22; k++) begin
      if (k < 5) I_data = 8'h20 + 8'(k);
      else I_valid = 1'b0;
      step();
    end
    checks++; if (O_swo !== 1'b0) begin errors++; $display("FAIL mid_bit4 got %b exp 0", O_swo); end
    checks++; if (O_fifo_count !== 5'd5) begin errors++; $display("FAIL mid_count got %0d exp 5", O_fifo_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (O_swo !== 1'b1) begin errors++; $display("FAIL mid_swo got %b exp 1", O_swo); end
    checks++; if (O_fifo_count !== 5'd0) begin errors++; $display("FAIL mid_flush got %0d exp 0", O_fifo_count); end
    checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", O_busy); end
    step();
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      checks++; if (O_swo !== 1'b1 || O_busy !== 1'b0) begin errors++; $display("FAIL mid_quiet k=%0d got swo %b busy %b exp 1/0", k, O_swo, O_busy); end
    end
    checks++; if (O_bytes_sent !== 16'd0) begin errors++; $display("FAIL mid_sent got %0d exp 0", O_bytes_sent); end
  endtask
`else
  task automatic test_manchester();
    logic [39:0] exp;
    exp = 40'b1100_1100_0011_0011_0011_0011_0011_0011_0011_0000;
    do_reset();
    I_div = 12'd1; I_enable = 1'b1; I_data = 8'h01; I_valid = 1'b1;
    step();
    I_valid = 1'b0;
    checks++; if (O_swo !== 1'b0) begin errors++; $display("FAIL man_pre got %b exp 0", O_swo); end
    for (int k = 0; k < 40; k++) begin
      step();
      checks++; if (O_swo !== exp[39-k]) begin errors++; $display("FAIL man_swo k=%0d got %b exp %b", k, O_swo, exp[39-k]); end
    end
    step();
    checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL man_idle got %b exp 0", O_busy); end
    checks++; if (O_bytes_sent !== 16'd1) begin errors++; $display("FAIL man_sent got %0d exp 1", O_bytes_sent); end
    checks++; if (O_swo !== 1'b0) begin errors++; $display("FAIL man_low got %b exp 0", O_swo); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef SWO_TX_MANCHESTER_EN
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_div_change();
    test_reset_mid_frame();
`else
    test_manchester();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
